// File: rtl/byte_word_packer.sv
// Packs valid bytes into 32-bit little-endian words and buffers them in a first-word-fall-through FIFO.
// Optional macro PACKER_PARITY_EN adds out_parity, a per-lane parity nibble carried with each word.
module byte_word_packer #(
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [7:0]               in_data,
    input  logic                     in_valid,
    input  logic                     flush,
    output logic [31:0]              out_data,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [$clog2(DEPTH):0]   out_count,
`ifdef PACKER_PARITY_EN
    output logic [3:0]               out_parity,
`endif
    output logic                     overflow
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [1:0]       bc_q, bc_d;
    logic [23:0]      asm_q, asm_d;
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             overflow_q, overflow_d;
    logic [31:0]      last_q, last_d;
    logic [31:0]      mem_q [DEPTH];

    logic [31:0]      word_cap;
    logic             push;
    logic             pop;
    logic             wr_en;
    logic             not_empty;
    logic             full;

`ifdef PACKER_PARITY_EN
    logic [3:0]       par_mem_q [DEPTH];
    logic [3:0]       word_par;
`endif

    assign not_empty = (count_q != '0);
    assign full      = (count_q == CNT_W'(DEPTH));

    always_comb begin
        word_cap = {8'h00, asm_q};
        if (in_valid) begin
            word_cap[{bc_q, 3'b000} +: 8] = in_data;
        end

        // A lone flush with no bytes collected has nothing to emit.
        push  = (in_valid && (bc_q == 2'd3)) || (flush && (in_valid || (bc_q != 2'd0)));
        pop   = not_empty && out_ready;
        wr_en = push && (!full || pop);

        asm_d = push ? 24'h0 : word_cap[23:0];
        bc_d  = bc_q;
        if (push) begin
            bc_d = 2'd0;
        end else if (in_valid) begin
            bc_d = bc_q + 2'd1;
        end

        wr_ptr_d = wr_en ? (wr_ptr_q + PTR_W'(1)) : wr_ptr_q;
        rd_ptr_d = pop   ? (rd_ptr_q + PTR_W'(1)) : rd_ptr_q;

        count_d = count_q;
        case ({wr_en, pop})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase

        overflow_d = overflow_q | (push & ~wr_en);
        last_d     = pop ? mem_q[rd_ptr_q] : last_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bc_q       <= 2'd0;
            asm_q      <= 24'h0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            overflow_q <= 1'b0;
            last_q     <= 32'h0;
        end else begin
            bc_q       <= bc_d;
            asm_q      <= asm_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            overflow_q <= overflow_d;
            last_q     <= last_d;
        end
    end

    // Storage needs no reset: count_q gates every read of it.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem_q[wr_ptr_q] <= word_cap;
        end
    end

    // When empty, out_data keeps showing the most recently popped word.
    assign out_data  = not_empty ? mem_q[rd_ptr_q] : last_q;
    assign out_valid = not_empty;
    assign out_count = count_q;
    assign overflow  = overflow_q;

`ifdef PACKER_PARITY_EN
    assign word_par = {^word_cap[31:24], ^word_cap[23:16], ^word_cap[15:8], ^word_cap[7:0]};

    always_ff @(posedge clk) begin
        if (wr_en) begin
            par_mem_q[wr_ptr_q] <= word_par;
        end
    end

    assign out_parity = not_empty ? par_mem_q[rd_ptr_q] : 4'h0;
`endif

endmodule

// File: tb/tb_byte_word_packer.sv
// Directed bench for byte_word_packer: vector table plus hand-written overflow, full-FIFO and reset sequences.
module tb_byte_word_packer;

    localparam int DEPTH = 4;

    logic        clk;
    logic        rst_n;
    logic [7:0]  in_data;
    logic        in_valid;
    logic        flush;
    logic [31:0] out_data;
    logic        out_valid;
    logic        out_ready;
    logic [2:0]  out_count;
    logic        overflow;
`ifdef PACKER_PARITY_EN
    logic [3:0]  out_parity;
`endif

    int checks = 0;
    int errors = 0;

    byte_word_packer #(.DEPTH(DEPTH)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_data   (in_data),
        .in_valid  (in_valid),
        .flush     (flush),
        .out_data  (out_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_count (out_count),
`ifdef PACKER_PARITY_EN
        .out_parity(out_parity),
`endif
        .overflow  (overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [7:0]  d;
        logic        v;
        logic        f;
        logic        r;
        logic        ev;
        logic [31:0] ed;
        int          ec;
        logic        eo;
    } vec_t;

    vec_t vecs[$];

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        in_data   = 8'h00;
        in_valid  = 1'b0;
        flush     = 1'b0;
        out_ready = 1'b0;
    endtask

    task automatic do_reset();
        idle_inputs();
        #2 rst_n = 1'b0;
        #10 rst_n = 1'b1;
        tick();
    endtask

    task automatic send_byte(input logic [7:0] b, input logic rdy);
        in_data   = b;
        in_valid  = 1'b1;
        out_ready = rdy;
        tick();
        idle_inputs();
    endtask

    task automatic drain_check(input logic [31:0] exp_w[4], input string tag);
        for (int i = 0; i < 4; i++) begin
            chk({tag, "_head_valid"}, {31'd0, out_valid}, 32'd1);
            chk({tag, "_head_data"}, out_data, exp_w[i]);
            out_ready = 1'b1;
            tick();
        end
        out_ready = 1'b0;
        chk({tag, "_empty_valid"}, {31'd0, out_valid}, 32'd0);
        chk({tag, "_empty_count"}, {29'd0, out_count}, 32'd0);
    endtask

    initial begin
        logic [31:0] words[5];
        logic [31:0] w4[4];

        rst_n = 1'b1;
        idle_inputs();

        // d, v, f, r | ev, ed, ec, eo
        vecs.push_back('{8'h11, 1, 0, 0, 0, 32'h00000000, 0, 0});
        vecs.push_back('{8'h22, 1, 0, 0, 0, 32'h00000000, 0, 0});
        vecs.push_back('{8'h33, 1, 0, 0, 0, 32'h00000000, 0, 0});
        vecs.push_back('{8'h44, 1, 0, 0, 1, 32'h44332211, 1, 0});
        vecs.push_back('{8'h00, 0, 0, 1, 0, 32'h44332211, 0, 0});
        vecs.push_back('{8'hAA, 1, 0, 0, 0, 32'h44332211, 0, 0});
        vecs.push_back('{8'hBB, 1, 0, 0, 0, 32'h44332211, 0, 0});
        vecs.push_back('{8'hCC, 1, 1, 0, 1, 32'h00CCBBAA, 1, 0});
        vecs.push_back('{8'h01, 1, 0, 1, 0, 32'h00CCBBAA, 0, 0});
        vecs.push_back('{8'h02, 1, 0, 0, 0, 32'h00CCBBAA, 0, 0});
        vecs.push_back('{8'h03, 1, 0, 0, 0, 32'h00CCBBAA, 0, 0});
        vecs.push_back('{8'h04, 1, 0, 0, 1, 32'h04030201, 1, 0});
        vecs.push_back('{8'h00, 0, 1, 0, 1, 32'h04030201, 1, 0});
        vecs.push_back('{8'h00, 0, 0, 1, 0, 32'h04030201, 0, 0});
        vecs.push_back('{8'h55, 1, 0, 0, 0, 32'h04030201, 0, 0});
        vecs.push_back('{8'h66, 1, 0, 0, 0, 32'h04030201, 0, 0});
        vecs.push_back('{8'h00, 0, 1, 0, 1, 32'h00006655, 1, 0});
        vecs.push_back('{8'hA1, 1, 0, 0, 1, 32'h00006655, 1, 0});
        vecs.push_back('{8'hA2, 1, 0, 0, 1, 32'h00006655, 1, 0});
        vecs.push_back('{8'hA3, 1, 0, 0, 1, 32'h00006655, 1, 0});
        vecs.push_back('{8'hA4, 1, 1, 0, 1, 32'h00006655, 2, 0});
        vecs.push_back('{8'h00, 0, 1, 0, 1, 32'h00006655, 2, 0});
        vecs.push_back('{8'h00, 0, 0, 1, 1, 32'hA4A3A2A1, 1, 0});
        vecs.push_back('{8'h00, 0, 0, 1, 0, 32'hA4A3A2A1, 0, 0});
        vecs.push_back('{8'h00, 0, 0, 1, 0, 32'hA4A3A2A1, 0, 0});

        do_reset();
        chk("reset_valid", {31'd0, out_valid}, 32'd0);
        chk("reset_data", out_data, 32'd0);
        chk("reset_count", {29'd0, out_count}, 32'd0);
        chk("reset_overflow", {31'd0, overflow}, 32'd0);

        for (int i = 0; i < vecs.size(); i++) begin
            in_data   = vecs[i].d;
            in_valid  = vecs[i].v;
            flush     = vecs[i].f;
            out_ready = vecs[i].r;
            tick();
            chk($sformatf("vec%0d_valid", i), {31'd0, out_valid}, {31'd0, vecs[i].ev});
            chk($sformatf("vec%0d_data", i), out_data, vecs[i].ed);
            chk($sformatf("vec%0d_count", i), {29'd0, out_count}, 32'(vecs[i].ec));
            chk($sformatf("vec%0d_overflow", i), {31'd0, overflow}, {31'd0, vecs[i].eo});
        end
        idle_inputs();

        // Overflow: five words into a four-deep FIFO with no consumer.
        words[0] = 32'h03020100;
        words[1] = 32'h07060504;
        words[2] = 32'h0B0A0908;
        words[3] = 32'h0F0E0D0C;
        words[4] = 32'h13121110;
        do_reset();
        for (int b = 0; b < 16; b++) send_byte(8'(b), 1'b0);
        chk("ovf_count_full", {29'd0, out_count}, 32'd4);
        chk("ovf_flag_before", {31'd0, overflow}, 32'd0);
        for (int b = 16; b < 20; b++) send_byte(8'(b), 1'b0);
        chk("ovf_count_after", {29'd0, out_count}, 32'd4);
        chk("ovf_flag_set", {31'd0, overflow}, 32'd1);
        repeat (3) tick();
        chk("ovf_flag_sticky", {31'd0, overflow}, 32'd1);
        for (int i = 0; i < 4; i++) w4[i] = words[i];
        drain_check(w4, "ovf_drain");
        chk("ovf_flag_after_drain", {31'd0, overflow}, 32'd1);

        // Full FIFO with a pop on the same edge the fifth word completes.
        do_reset();
        for (int b = 0; b < 16; b++) send_byte(8'(b), 1'b0);
        for (int b = 16; b < 19; b++) send_byte(8'(b), 1'b0);
        send_byte(8'h13, 1'b1);
        chk("pp_count", {29'd0, out_count}, 32'd4);
        chk("pp_overflow", {31'd0, overflow}, 32'd0);
        for (int i = 0; i < 4; i++) w4[i] = words[i + 1];
        drain_check(w4, "pp_drain");

        // Asynchronous reset mid-word with a word already buffered.
        do_reset();
        send_byte(8'h51, 1'b0);
        send_byte(8'h52, 1'b0);
        send_byte(8'h53, 1'b0);
        send_byte(8'h54, 1'b0);
        send_byte(8'h01, 1'b0);
        send_byte(8'h02, 1'b0);
        send_byte(8'h03, 1'b0);
        chk("pre_rst_valid", {31'd0, out_valid}, 32'd1);
        #2 rst_n = 1'b0;
        #1;
        chk("arst_valid", {31'd0, out_valid}, 32'd0);
        chk("arst_data", out_data, 32'd0);
        chk("arst_count", {29'd0, out_count}, 32'd0);
        #10 rst_n = 1'b1;
        tick();
        send_byte(8'hDE, 1'b0);
        send_byte(8'hAD, 1'b0);
        send_byte(8'hBE, 1'b0);
        chk("post_rst_partial", {31'd0, out_valid}, 32'd0);
        send_byte(8'hEF, 1'b0);
        chk("post_rst_valid", {31'd0, out_valid}, 32'd1);
        chk("post_rst_data", out_data, 32'hEFBEADDE);
        chk("post_rst_count", {29'd0, out_count}, 32'd1);

`ifdef PACKER_PARITY_EN
        do_reset();
        chk("par_reset", {28'd0, out_parity}, 32'd0);
        send_byte(8'h01, 1'b0);
        send_byte(8'h03, 1'b0);
        send_byte(8'hFF, 1'b0);
        send_byte(8'h80, 1'b0);
        chk("par_data", out_data, 32'h80FF0301);
        chk("par_value", {28'd0, out_parity}, 32'h9);
        in_data  = 8'h07;
        in_valid = 1'b1;
        flush    = 1'b1;
        tick();
        idle_inputs();
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        chk("par_pad_data", out_data, 32'h00000007);
        chk("par_pad_value", {28'd0, out_parity}, 32'h1);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        chk("par_empty", {28'd0, out_parity}, 32'd0);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
